// File: rtl/regbus_arbiter.sv
// ============================================================================
// Module   : regbus_arbiter
// Brief    : Round-robin two-master arbiter for the pmsre register bus with
//            request/done handshake and single-cycle read/write strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbus_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_read,
    output logic              s_write,
    input  logic [DATA_W-1:0] s_rdata
);

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_owner;     // 1 = master 1 owns the current transaction
    logic               r_last;      // 1 = master 1 was served last
    logic               r_is_write;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_any_req;
    logic               w_win;
    logic               w_win_write;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [DATA_W-1:0]  w_win_wdata;
    logic               w_enter_done;

    assign w_any_req   = m0_req | m1_req;
    // On a tie the master that was not served last wins.
    assign w_win       = (m0_req & m1_req) ? ~r_last : m1_req;
    assign w_win_write = w_win ? m1_write : m0_write;
    assign w_win_addr  = w_win ? m1_addr  : m0_addr;
    assign w_win_wdata = w_win ? m1_wdata : m0_wdata;

    // The edge that ends ISSUE (write or zero-latency read) or the last WAIT cycle.
    assign w_enter_done = ((r_state == S_ISSUE) && (r_is_write || (READ_LAT == 0))) ||
                          ((r_state == S_WAIT) && (r_cnt == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_read     <= 1'b0;
            s_write    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner    <= w_win;
                        r_is_write <= w_win_write;
                        s_addr     <= w_win_addr;
                        s_wdata    <= w_win_wdata;
                        s_write    <= w_win_write;
                        s_read     <= ~w_win_write;
                        m0_gnt     <= ~w_win;
                        m1_gnt     <= w_win;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    s_write <= 1'b0;
                    s_read  <= 1'b0;
                    if (!w_enter_done) begin
                        r_cnt   <= CNT_W'(READ_LAT - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_enter_done) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    m0_done <= 1'b0;
                    m1_done <= 1'b0;
                    m0_gnt  <= 1'b0;
                    m1_gnt  <= 1'b0;
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_enter_done) begin
                r_state <= S_DONE;
                m0_done <= ~r_owner;
                m1_done <= r_owner;
                if (!r_is_write) begin
                    if (r_owner) begin
                        m1_rdata <= s_rdata;
                    end else begin
                        m0_rdata <= s_rdata;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regbus_arbiter.sv
// ============================================================================
// Module   : tb_regbus_arbiter
// Brief    : Checks two arbiter instances (READ_LAT 0 and 2) against a
//            transaction-timing reference model, directed then random.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regbus_arbiter;

    localparam int LAT_A = 0;
    localparam int LAT_B = 2;

    logic        clk;
    logic        reset;
    logic [31:0] s_rdata;

    logic        m_req   [2][2];
    logic        m_write [2][2];
    logic [6:0]  m_addr  [2][2];
    logic [31:0] m_wdata [2][2];
    logic        hold    [2][2];

    logic        gnt     [2][2];
    logic        done    [2][2];
    logic [31:0] rdata   [2][2];
    logic [6:0]  s_addr  [2];
    logic [31:0] s_wdata [2];
    logic        s_read  [2];
    logic        s_write [2];

    // Reference model: one record per DUT describing the transaction in flight.
    bit          md_busy  [2];
    bit          md_win   [2];
    bit          md_rd    [2];
    int          md_k     [2];
    bit          md_last  [2];
    logic [6:0]  md_addr  [2];
    logic [31:0] md_wdata [2];
    logic [31:0] md_rdata [2][2];

    int n;
    int vectors;
    int errors;

    regbus_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(LAT_A)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m_req[0][0]),
        .m0_write (m_write[0][0]),
        .m0_addr  (m_addr[0][0]),
        .m0_wdata (m_wdata[0][0]),
        .m1_req   (m_req[0][1]),
        .m1_write (m_write[0][1]),
        .m1_addr  (m_addr[0][1]),
        .m1_wdata (m_wdata[0][1]),
        .m0_gnt   (gnt[0][0]),
        .m0_done  (done[0][0]),
        .m0_rdata (rdata[0][0]),
        .m1_gnt   (gnt[0][1]),
        .m1_done  (done[0][1]),
        .m1_rdata (rdata[0][1]),
        .s_addr   (s_addr[0]),
        .s_wdata  (s_wdata[0]),
        .s_read   (s_read[0]),
        .s_write  (s_write[0]),
        .s_rdata  (s_rdata)
    );

    regbus_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(LAT_B)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m_req[1][0]),
        .m0_write (m_write[1][0]),
        .m0_addr  (m_addr[1][0]),
        .m0_wdata (m_wdata[1][0]),
        .m1_req   (m_req[1][1]),
        .m1_write (m_write[1][1]),
        .m1_addr  (m_addr[1][1]),
        .m1_wdata (m_wdata[1][1]),
        .m0_gnt   (gnt[1][0]),
        .m0_done  (done[1][0]),
        .m0_rdata (rdata[1][0]),
        .m1_gnt   (gnt[1][1]),
        .m1_done  (done[1][1]),
        .m1_rdata (rdata[1][1]),
        .s_addr   (s_addr[1]),
        .s_wdata  (s_wdata[1]),
        .s_read   (s_read[1]),
        .s_write  (s_write[1]),
        .s_rdata  (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the rules to the inputs seen at edge n; the result describes cycle n+1.
    task automatic advance(input int d);
        int L;
        if (reset) begin
            md_busy[d]  = 1'b0;
            md_last[d]  = 1'b1;
            md_addr[d]  = '0;
            md_wdata[d] = '0;
            md_rdata[d][0] = '0;
            md_rdata[d][1] = '0;
        end else if (!md_busy[d]) begin
            if (m_req[d][0] || m_req[d][1]) begin
                if (m_req[d][0] && m_req[d][1]) md_win[d] = !md_last[d];
                else                            md_win[d] = m_req[d][1];
                md_busy[d]  = 1'b1;
                md_k[d]     = n;
                md_rd[d]    = !m_write[d][md_win[d]];
                md_addr[d]  = m_addr[d][md_win[d]];
                md_wdata[d] = m_wdata[d][md_win[d]];
            end
        end else begin
            L = md_rd[d] ? lat_of(d) : 0;
            if (md_rd[d] && n == md_k[d] + 1 + L) md_rdata[d][md_win[d]] = s_rdata;
            if (n == md_k[d] + 2 + L) begin
                md_busy[d] = 1'b0;
                md_last[d] = md_win[d];
            end
        end
    endtask

    task automatic check(input int d);
        int L;
        bit is_issue;
        bit is_done;
        L = md_rd[d] ? lat_of(d) : 0;
        is_issue = md_busy[d] && (n == md_k[d]);
        is_done  = md_busy[d] && (n == md_k[d] + 1 + L);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("d%0d gnt%0d @%0d", d, m, n), 32'(gnt[d][m]),
                32'(md_busy[d] && (int'(md_win[d]) == m)));
            chk($sformatf("d%0d done%0d @%0d", d, m, n), 32'(done[d][m]),
                32'(is_done && (int'(md_win[d]) == m)));
            chk($sformatf("d%0d rdata%0d @%0d", d, m, n), rdata[d][m], md_rdata[d][m]);
        end
        chk($sformatf("d%0d s_write @%0d", d, n), 32'(s_write[d]), 32'(is_issue && !md_rd[d]));
        chk($sformatf("d%0d s_read @%0d", d, n), 32'(s_read[d]), 32'(is_issue && md_rd[d]));
        chk($sformatf("d%0d s_addr @%0d", d, n), 32'(s_addr[d]), 32'(md_addr[d]));
        chk($sformatf("d%0d s_wdata @%0d", d, n), s_wdata[d], md_wdata[d]);
    endtask

    // One clock: model update and full output check, then master handshake.
    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            advance(d);
            check(d);
        end
        n++;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++)
                if (done[d][m] && !hold[d][m]) m_req[d][m] = 1'b0;
    endtask

    task automatic req(input int d, input int m, input bit wr, input logic [6:0] a,
                       input logic [31:0] wd);
        m_req[d][m]   = 1'b1;
        m_write[d][m] = wr;
        m_addr[d][m]  = a;
        m_wdata[d][m] = wd;
    endtask

    task automatic clear_all();
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                m_req[d][m] = 1'b0;
                hold[d][m]  = 1'b0;
            end
    endtask

    initial begin
        n = 0;
        vectors = 0;
        errors = 0;
        reset = 1'b1;
        s_rdata = '0;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                m_req[d][m] = 1'b0;  m_write[d][m] = 1'b0;
                m_addr[d][m] = '0;   m_wdata[d][m] = '0;
                hold[d][m] = 1'b0;
            end
        repeat (3) step();
        reset = 1'b0;
        step();

        // Write on the zero-latency instance, read on the two-cycle instance.
        req(0, 0, 1'b1, 7'h05, 32'hDEADBEEF);
        req(1, 1, 1'b0, 7'h7F, 32'h0);
        s_rdata = 32'h12345678;
        step();
        chk("A s_write k+1", 32'(s_write[0]), 32'd1);
        chk("A s_addr k+1", 32'(s_addr[0]), 32'h05);
        chk("A s_wdata k+1", s_wdata[0], 32'hDEADBEEF);
        step();
        chk("A s_write k+2", 32'(s_write[0]), 32'd0);
        chk("A m0_done k+2", 32'(done[0][0]), 32'd1);
        step();
        step();
        chk("A m1_done k+4", 32'(done[1][1]), 32'd1);
        chk("A m1_rdata k+4", rdata[1][1], 32'h12345678);
        chk("A m0_rdata untouched", rdata[1][0], 32'h0);
        repeat (2) step();

        // Both masters request continuously after a fresh reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req(0, 0, 1'b1, 7'h01, 32'h1111_0001);
        req(0, 1, 1'b1, 7'h02, 32'h2222_0002);
        hold[0][0] = 1'b1;
        hold[0][1] = 1'b1;
        step();
        chk("B first gnt m0", 32'(gnt[0][0]), 32'd1);
        chk("B first addr", 32'(s_addr[0]), 32'h01);
        repeat (3) step();
        chk("B second gnt m1", 32'(gnt[0][1]), 32'd1);
        chk("B second addr", 32'(s_addr[0]), 32'h02);
        repeat (3) step();
        chk("B third addr", 32'(s_addr[0]), 32'h01);
        repeat (6) step();
        clear_all();
        repeat (6) step();

        // m0 read drops req during ISSUE; m1 requests mid-transaction.
        req(0, 0, 1'b0, 7'h11, 32'h0);
        s_rdata = 32'hCAFE_F00D;
        step();
        m_req[0][0] = 1'b0;
        req(0, 1, 1'b1, 7'h22, 32'h5555_AAAA);
        step();
        chk("C m0_done", 32'(done[0][0]), 32'd1);
        chk("C m0_rdata", rdata[0][0], 32'hCAFE_F00D);
        step();
        chk("C idle gnt", 32'(gnt[0][1]), 32'd0);
        chk("C s_addr held", 32'(s_addr[0]), 32'h11);
        step();
        chk("C m1 issue", 32'(s_write[0]), 32'd1);
        chk("C m1 addr", 32'(s_addr[0]), 32'h22);
        repeat (3) step();
        clear_all();
        repeat (4) step();

        // Reset during WAIT of a read on the two-cycle instance.
        req(1, 1, 1'b0, 7'h33, 32'h0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("D gnt after reset", 32'(gnt[1][1]), 32'd0);
        chk("D s_addr after reset", 32'(s_addr[1]), 32'h0);
        step();
        chk("D no done", 32'(done[1][1]), 32'd0);
        repeat (6) step();
        clear_all();
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req(1, 0, 1'b1, 7'h44, 32'h4444_4444);
        req(1, 1, 1'b1, 7'h55, 32'h5555_5555);
        step();
        chk("D tie to m0", 32'(gnt[1][0]), 32'd1);
        repeat (8) step();
        clear_all();
        repeat (4) step();

        // Random traffic with occasional resets and early req drops.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 249) == 0);
            s_rdata = $urandom;
            for (int d = 0; d < 2; d++)
                for (int m = 0; m < 2; m++) begin
                    hold[d][m] = 1'($urandom);
                    if (!m_req[d][m]) begin
                        m_write[d][m] = 1'($urandom);
                        m_addr[d][m]  = 7'($urandom);
                        m_wdata[d][m] = $urandom;
                        m_req[d][m]   = ($urandom_range(0, 2) == 0);
                    end else if (gnt[d][m] && !done[d][m] && $urandom_range(0, 7) == 0) begin
                        m_req[d][m] = 1'b0;
                    end
                end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regbus_arbiter.md
# regbus_arbiter

Two-master arbiter for the 7-bit-address, 32-bit-data register bus of the `pmsre` motor-control register bank. It shares that bus between two masters:
- master 0: the SPI-side `bus_fsm`;
- master 1: an on-chip requester, such as a motion sequencer.

It uses round-robin arbitration and a request/done handshake, and generates the single-cycle `read`/`write` strobes the register bank expects. It sits between the masters and `pmsre`, in the `clk_8mhz` domain.

## Interface
Parameters:
- `ADDR_W`, default 7: register address width.
- `DATA_W`, default 32: data width.
- `READ_LAT`, default 0: cycles after the read-strobe cycle until `s_rdata` is valid. Legal range 0..3.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  transaction request; held high until `mX_done`.
- `m0_write`, `m1_write`  in  1  1 = write, 0 = read; valid while `req` is high.
- `m0_addr`, `m1_addr`  in  `ADDR_W`  register address.
- `m0_wdata`, `m1_wdata`  in  `DATA_W`  write data.
- `m0_gnt`, `m1_gnt`  out  1  master owns the bus; high from ISSUE through DONE.
- `m0_done`, `m1_done`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  `DATA_W`  read result; valid while `done` is high, held until the next read by that master.
- `s_addr`  out  `ADDR_W`  address to `pmsre`.
- `s_wdata`  out  `DATA_W`  write data to `pmsre`.
- `s_read`, `s_write`  out  1  single-cycle strobes to `pmsre`.
- `s_rdata`  in  `DATA_W`  read data from `pmsre`.

## Operation
States:
- **IDLE**
  - Requests are sampled only in this state.
  - Exactly one `req` high: that master wins.
  - Both high: the master not served last wins.
  - On the transition out, latch the winner's `addr`, `wdata` and `write` into the `s_*` registers. Then go to ISSUE.
- **ISSUE** (1 cycle)
  - The winner's `gnt` is high.
  - `s_write` is high for a write, `s_read` for a read; never both.
  - Next state: a write goes to DONE. A read goes to WAIT if `READ_LAT` > 0, else to DONE.
- **WAIT** (exactly `READ_LAT` cycles)
  - A down-counter sized for `READ_LAT`; strobes are low.
  - Exit to DONE.
- **DONE** (1 cycle)
  - The winner's `done` is high.
  - For a read, the winner's `rdata` was loaded from `s_rdata` at the edge entering DONE.
  - Update the last-served flag. Return to IDLE.

Rules:
- `s_addr` and `s_wdata` hold their latched values after DONE; they change only at the next grant.
- The loser's `done` and `rdata` are unaffected.
- Dropping `req` after grant is ignored: the transaction completes and `done` still pulses.
- The other master's address and data are never driven to `s_*` during a transaction.
- A master holding `req` high through `done` is a new request at the next IDLE sample. If the other master is also requesting, round-robin serves the other master first.
- There is no combinational path from any `mX_*` input to any `s_*` output.

## Timing
- Reset values: state IDLE; all strobes, `gnt` and `done` 0; `s_addr`, `s_wdata`, `m0_rdata`, `m1_rdata` 0.
- After reset the last-served flag is master 1, so master 0 (SPI) wins the first tie.
- Reset mid-transaction:
  - IDLE at the next edge.
  - Strobes and `gnt` low in the following cycle.
  - No `done` is issued for the aborted transaction.
- With `req` first sampled high at edge k:
  - ISSUE (strobe) occurs in cycle k+1.
  - A write's `done` is in cycle k+2.
  - A read's `done` is in cycle k+2+`READ_LAT`; `s_rdata` is sampled at the edge ending cycle k+1+`READ_LAT`.
- Back-to-back transactions cost one IDLE cycle.
- Issue interval:
  - Writes: one transaction per 3 cycles.
  - Reads: one per 3+`READ_LAT` cycles.

## Test plan
- `READ_LAT`=0, m0 write addr 0x05 data 0xDEADBEEF:
  - `s_write` high for exactly 1 cycle with `s_addr`=0x05, `s_wdata`=0xDEADBEEF;
  - `m0_done` pulses 2 cycles after `req` is sampled.
- `READ_LAT`=2, m1 read addr 0x7F, `s_rdata` model returns 0x12345678 two cycles after the strobe:
  - `m1_rdata`=0x12345678 with `m1_done` in cycle k+4;
  - `m0_rdata` unchanged.
- Both masters hold `req` continuously, writing 0x01 (m0) and 0x02 (m1):
  - strobes alternate m0, m1, m0, m1 starting with m0 after reset;
  - one `s_write` every 3 cycles;
  - `gnt` is never high for both masters.
- m0 read granted, m0 drops `req` during ISSUE, and m1 raises `req` mid-transaction:
  - m0 transaction completes with `m0_done`;
  - m1's ISSUE follows exactly 1 IDLE cycle later;
  - `s_addr` is unchanged until then.
- `reset` asserted during WAIT of a read:
  - no `done` pulse;
  - all outputs return to their reset values;
  - the next tie goes to m0.
